y_event_monitor: RTL and testbench

- Consumes the glitch-prone combinational output y of the three-input sum-of-products stage.
- Synchronises y into the system clock and filters out glitches and hazards by requiring a minimum stable time.
- Detects rising and falling edges of the filtered signal and counts the rising edges.
- Lets a host capture a snapshot of the count through a valid/ready handshake. Sits directly downstream of the y-producing logic, on the board clock.

---
 rtl/y_event_monitor.sv | 126 ++++++++++++
 tb/tb_y_event_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_event_monitor.sv
// y_event_monitor
// Cleans up the hazard-prone y output of the sum-of-products stage.
// The block synchronises y, removes short glitches, flags filtered edges and
// counts rising edges. A host can capture the count through a valid/ready
// snapshot port.

module y_event_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             y_in,
   input  logic             clr,
   output logic             filt_y,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] count,
   output logic             count_sat,
   input  logic             snap_req,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic [CNT_W:0]   snap_data
);

   // The stability counter must be able to hold FILTER_LEN-1. Its last value
   // is where the filtered output is allowed to follow ysync.
   localparam int              STAB_W    = $clog2(FILTER_LEN + 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ysync;
   logic [STAB_W-1:0]      stab_cnt;
   logic [0:0]             state;

   assign ysync = sync_q[SYNC_STAGES-1];

   // Shift the asynchronous y through the synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], y_in};
      end
   end

   // filt_y follows ysync only after FILTER_LEN consecutive disagreeing
   // cycles. The edge pulses are registered with the same update, so each
   // pulse lines up with the first cycle that shows the new level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stab_cnt   <= '0;
         filt_y     <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         if (ysync == filt_y) begin
            stab_cnt <= '0;
         end else if (stab_cnt == STAB_LAST) begin
            stab_cnt   <= '0;
            filt_y     <= ysync;
            rise_pulse <= ysync;
            fall_pulse <= ~ysync;
         end else begin
            stab_cnt <= stab_cnt + 1'b1;
         end
      end
   end

   // Count filtered rising edges. The counter saturates at all-ones, and the
   // sticky flag marks that saturation. A clear overrides a simultaneous
   // increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         count_sat <= 1'b0;
      end else if (clr) begin
         count     <= '0;
         count_sat <= 1'b0;
      end else if (rise_pulse && (count != CNT_MAX)) begin
         count <= count + 1'b1;
         if (count == (CNT_MAX - 1'b1)) begin
            count_sat <= 1'b1;
         end
      end
   end

   // Snapshot handshake. The pre-edge count is captured, so an increment in
   // the same cycle is not included. Requests arriving during HOLD are
   // dropped, including a request in the accept cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         snap_valid <= 1'b0;
         snap_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (snap_req) begin
                  snap_data  <= {count_sat, count};
                  snap_valid <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (snap_ready) begin
                  snap_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               snap_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_y_event_monitor.sv
// Testbench for y_event_monitor (CNT_W=3 so saturation is reached quickly).
// Expected filtered edges and snapshots are queued as stimulus is driven.
// A monitor pops them when the DUT produces them. The monitor also tracks the
// expected count, sticky flag and handshake state on every cycle.

module tb_y_event_monitor;

   localparam int CNT_W = 3;
   localparam int LAT   = 6;

   typedef struct {
      logic is_rise;
      int   cyc;
   } pulse_t;

   logic             clk;
   logic             rst_n;
   logic             y_in;
   logic             clr;
   logic             filt_y;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] count;
   logic             count_sat;
   logic             snap_req;
   logic             snap_valid;
   logic             snap_ready;
   logic [CNT_W:0]   snap_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   pulse_t       exp_pulse[$];
   logic [CNT_W:0] exp_snap[$];

   logic [CNT_W-1:0] m_cnt;
   logic             m_sat;
   logic             m_filt;
   logic             m_hold;
   logic [CNT_W:0]   m_snap;
   logic             prev_rise;

   y_event_monitor #(
      .SYNC_STAGES(2),
      .FILTER_LEN (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .y_in      (y_in),
      .clr       (clr),
      .filt_y    (filt_y),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .count     (count),
      .count_sat (count_sat),
      .snap_req  (snap_req),
      .snap_valid(snap_valid),
      .snap_ready(snap_ready),
      .snap_data (snap_data)
   );

   // The clock has a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count the clock edges, so that expected pulse times can be stated in cycles.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive a new y level. When it should survive the filter, queue the
   // filtered edge at the fixed sync+filter latency.
   task automatic drive_y(input logic v, input logic expect_edge);
      y_in = v;
      if (expect_edge) exp_pulse.push_back('{is_rise: v, cyc: cyc + LAT});
   endtask

   task automatic pulse_y(input int len);
      drive_y(1'b1, len >= 4);
      step(len);
      drive_y(1'b0, len >= 4);
      step(12);
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_filt_y"}, filt_y, 0);
      check_output({tag, "_rise"}, rise_pulse, 0);
      check_output({tag, "_fall"}, fall_pulse, 0);
      check_output({tag, "_count"}, count, 0);
      check_output({tag, "_sat"}, count_sat, 0);
      check_output({tag, "_snap_valid"}, snap_valid, 0);
      check_output({tag, "_snap_data"}, snap_data, 0);
   endtask

   // The monitor samples 1 ns after each rising edge. Inputs seen at that
   // point are the values the edge sampled. prev_rise holds the pre-edge pulse.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            m_cnt = '0; m_sat = 1'b0; m_filt = 1'b0; m_hold = 1'b0; prev_rise = 1'b0;
         end else begin
            if (clr) begin
               m_cnt = '0;
               m_sat = 1'b0;
            end else if (prev_rise) begin
               if (m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
               if (m_cnt == 3'd7) m_sat = 1'b1;
            end
            prev_rise = rise_pulse;

            if (!m_hold && snap_req) begin
               if (exp_snap.size() == 0) begin
                  check_output("snap_unexpected", 1, 0);
                  m_snap = snap_data;
               end else begin
                  m_snap = exp_snap.pop_front();
               end
               m_hold = 1'b1;
            end else if (m_hold && snap_ready) begin
               m_hold = 1'b0;
            end

            check_output("pulse_excl", rise_pulse & fall_pulse, 0);
            if (rise_pulse || fall_pulse) begin
               if (exp_pulse.size() == 0) begin
                  check_output("pulse_unexpected", 1, 0);
               end else begin
                  pulse_t p;
                  p = exp_pulse.pop_front();
                  check_output("pulse_kind", rise_pulse, p.is_rise);
                  check_output("pulse_cycle", cyc, p.cyc);
                  m_filt = p.is_rise;
               end
            end
            if (exp_pulse.size() > 0 && exp_pulse[0].cyc < cyc) begin
               check_output("pulse_missed", 0, 1);
               void'(exp_pulse.pop_front());
            end

            check_output("filt_y", filt_y, m_filt);
            check_output("count", count, m_cnt);
            check_output("count_sat", count_sat, m_sat);
            check_output("snap_valid", snap_valid, m_hold);
            if (m_hold) check_output("snap_data", snap_data, m_snap);
         end
      end
   end

   // Stop the run if the stimulus ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      rst_n = 1'b0; y_in = 1'b0; clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
      step(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      step(2);

      // A clean step up is followed by a step down.
      drive_y(1'b1, 1'b1);
      step(10);
      check_output("count_first_rise", count, 1);
      drive_y(1'b0, 1'b1);
      step(10);

      // A 3-cycle glitch is filtered out. A 4-cycle pulse gets through.
      pulse_y(3);
      check_output("count_after_glitch", count, 1);
      pulse_y(4);
      check_output("count_after_min_pulse", count, 2);

      repeat (3) pulse_y(5);
      check_output("count_five", count, 5);
      check_output("sat_at_five", count_sat, 0);

      // Capture 0_101 and hold it while two more rises occur. The request
      // in the accept cycle must not capture.
      snap_req = 1'b1;
      exp_snap.push_back(4'b0101);
      step(1);
      snap_req = 1'b0;
      repeat (2) pulse_y(5);
      check_output("held_snap_data", snap_data, 4'b0101);
      snap_ready = 1'b1;
      snap_req   = 1'b1;
      step(1);
      snap_ready = 1'b0;
      snap_req   = 1'b0;
      step(2);
      check_output("snap_valid_after_accept", snap_valid, 0);
      check_output("count_seven", count, 7);
      check_output("sat_at_seven", count_sat, 1);

      // A fresh capture after an idle cycle
      snap_req = 1'b1;
      exp_snap.push_back(4'b1111);
      step(1);
      snap_req = 1'b0;
      step(3);
      snap_ready = 1'b1;
      step(1);
      snap_ready = 1'b0;
      step(2);

      // The counter holds at saturation.
      repeat (2) pulse_y(5);
      check_output("count_saturated", count, 7);
      check_output("sat_sticky", count_sat, 1);

      // A clear in the same cycle as rise_pulse wins over the increment.
      drive_y(1'b1, 1'b1);
      step(LAT);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      drive_y(1'b0, 1'b1);
      step(12);
      check_output("count_after_clr", count, 0);
      check_output("sat_after_clr", count_sat, 0);
      pulse_y(5);
      check_output("count_after_clr_rise", count, 1);

      // Assert reset with the filter mid-count and a snapshot in HOLD.
      drive_y(1'b1, 1'b1);
      step(10);
      snap_req = 1'b1;
      exp_snap.push_back(4'b0010);
      step(1);
      snap_req = 1'b0;
      step(2);
      drive_y(1'b0, 1'b0);
      step(4);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      y_in = 1'b1;
      step(3);
      rst_n = 1'b1;
      drive_y(1'b1, 1'b1);
      step(LAT - 1);
      check_output("filt_before_latency", filt_y, 0);
      step(1);
      check_output("filt_at_latency", filt_y, 1);
      step(4);
      check_output("count_after_reset_rise", count, 1);
      drive_y(1'b0, 1'b1);
      step(12);

      check_output("pulse_queue_left", exp_pulse.size(), 0);
      check_output("snap_queue_left", exp_snap.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
